// File: rtl/rd_data_byte_align.sv
// rd_data_byte_align: pops one byte offset per AXI read burst from low_araddr_fifo
// and realigns the R beat stream so each output word starts at that byte.
// A burst of BURST_LEN input beats yields BURST_LEN-1 aligned output words.
module rd_data_byte_align #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned OFF_W     = 4,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [OFF_W-1:0]  fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              err_burst
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned SH_W  = OFF_W + 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_FIRST  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OFF_W-1:0]    r_off;
  logic [DATA_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_valid;
  logic                r_m_last;
  logic                r_err;

  logic                w_rd_en;
  logic                w_rready;
  logic                w_accept;
  logic                w_last_beat;
  logic [2*DATA_W-1:0] w_cat;
  logic [SH_W-1:0]     w_shift;
  logic [DATA_W-1:0]   w_word;

  // r_cnt holds the number of beats already accepted in this burst
  assign w_last_beat = (r_cnt == CNT_W'(BURST_LEN - 1));
  assign w_accept    = s_rvalid & w_rready;

  // Previous beat in the low half, current beat on top; shift selects the starting byte
  assign w_cat   = {s_rdata, r_hold};
  assign w_shift = {r_off, 3'b000};
  assign w_word  = DATA_W'(w_cat >> w_shift);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, FIFO pop and R-channel ready
  always_comb begin
    w_next   = r_state;
    w_rd_en  = 1'b0;
    w_rready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_rd_empty) begin
          w_rd_en = 1'b1;
          w_next  = S_POP;
        end
      end
      S_POP: begin
        w_next = S_FIRST;
      end
      S_FIRST: begin
        w_rready = 1'b1;
        if (s_rvalid) begin
          w_next = S_STREAM;
        end
      end
      S_STREAM: begin
        w_rready = !r_m_valid || m_ready;
        if (s_rvalid && w_rready && w_last_beat) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Offset latch, beat hold, beat counter and the single output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off     <= '0;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      if (r_state == S_POP) begin
        r_off <= fifo_rd_data;
      end
      if (w_accept && (r_state == S_FIRST)) begin
        r_hold <= s_rdata;
        r_cnt  <= CNT_W'(1);
      end
      if (w_accept && (r_state == S_STREAM)) begin
        r_hold    <= s_rdata;
        r_m_data  <= w_word;
        r_m_valid <= 1'b1;
        r_m_last  <= w_last_beat;
        r_cnt     <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  // Sticky flag: rlast present/absent on the wrong beat of a burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && (s_rlast != w_last_beat)) begin
      r_err <= 1'b1;
    end
  end

  // Pop is suppressed while held in reset so no offset is lost
  assign fifo_rd_en = w_rd_en & rst_n;
  assign s_rready   = w_rready;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;
  assign err_burst  = r_err;

endmodule

// File: tb/tb_rd_data_byte_align.sv
// Bench for rd_data_byte_align: FIFO model, R-channel driver, scoreboard monitor.
module tb_rd_data_byte_align;

  localparam int DW = 128;
  localparam int OW = 4;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [OW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic [DW-1:0] s_rdata = '0;
  logic          s_rvalid = 1'b0;
  logic          s_rlast = 1'b0;
  logic          s_rready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b1;
  logic          err_burst;

  rd_data_byte_align #(.DATA_W(DW), .OFF_W(OW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .err_burst(err_burst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned fq[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          empty_pop = 0;
  int          n_push = 0;
  int          viol = 0;
  int          rmode = 0;
  bit          gap_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_off(input int unsigned o);
    fq.push_back(o);
    n_push++;
  endtask

  // Non-FWFT FIFO model: data appears the cycle after the pop request
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      if (fq.size() == 0) empty_pop++;
      else fifo_rd_data <= OW'(fq.pop_front());
    end
    fifo_rd_empty <= (fq.size() == 0);
  end

  // Downstream ready: always, alternating, or random
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare every transferred word against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && !m_ready && s_rready) viol++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", m_data, e.d);
          check("word_last", DW'(m_last), DW'(e.l));
        end
      end
    end
  end

  // Issue one burst; the reference output is the byte stream read from offset 16*w+off
  task automatic send_burst(input int off, input int kind, input int rlast_beat, input int rst_beat);
    logic [DW-1:0] beats[BL];
    logic [DW-1:0] word;
    int            k;
    int            c;
    for (int i = 0; i < BL; i++) begin
      for (int j = 0; j < DW / 8; j++) begin
        case (kind)
          0:       beats[i][8*j +: 8] = 8'(i);
          1:       beats[i][8*j +: 8] = 8'(16 * i + j);
          default: beats[i][8*j +: 8] = 8'($urandom_range(0, 255));
        endcase
      end
    end
    for (int w = 0; w < BL - 1; w++) begin
      for (int j = 0; j < DW / 8; j++) begin
        k = 16 * w + off + j;
        word[8*j +: 8] = beats[k / 16][8 * (k % 16) +: 8];
      end
      exp_q.push_back('{d: word, l: (w == BL - 2)});
    end
    for (int i = 0; i < BL; i++) begin
      if (gap_en) begin
        repeat ($urandom_range(0, 2)) begin
          s_rvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_rvalid = 1'b1;
      s_rdata  = beats[i];
      s_rlast  = (i + 1 == rlast_beat);
      c = 0;
      @(negedge clk);
      while (!s_rready && c < 500) begin
        c++;
        @(negedge clk);
      end
      if (!s_rready) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got no s_rready expected s_rready within 500 cycles");
        s_rvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (i + 1 == rlast_beat && rlast_beat != BL) check("err_next_cycle", DW'(err_burst), DW'(1));
      if (i + 1 == rst_beat) begin
        rst_n    = 1'b0;
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        exp_q.delete();
        return;
      end
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      c++;
      @(negedge clk);
    end
    check("drain_left", DW'(exp_q.size()), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   DW'(fifo_rd_en), DW'(0));
    check({tag, "_rready"},  DW'(s_rready),   DW'(0));
    check({tag, "_m_valid"}, DW'(m_valid),    DW'(0));
    check({tag, "_m_last"},  DW'(m_last),     DW'(0));
    check({tag, "_err"},     DW'(err_burst),  DW'(0));
    check({tag, "_m_data"},  m_data,          DW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs idle, no pop even with a non-empty FIFO
    push_off(0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // off=0, replicated beats: pure one-beat delay
    rmode = 0;
    send_burst(0, 0, BL, 0);
    drain();
    check("t1_rd_pulses", DW'(rd_cnt), DW'(1));
    check("t1_err", DW'(err_burst), DW'(0));

    // off=5, byte-indexed beats
    push_off(5);
    send_burst(5, 1, BL, 0);
    drain();

    // off=15 with alternating downstream ready
    rmode = 1;
    push_off(15);
    send_burst(15, 1, BL, 0);
    drain();
    check("t3_rready_backpressure", DW'(viol), DW'(0));

    // Three queued offsets, back-to-back bursts
    rmode = 0;
    push_off(3);
    push_off(0);
    push_off(9);
    send_burst(3, 2, BL, 0);
    send_burst(0, 2, BL, 0);
    send_burst(9, 2, BL, 0);
    drain();
    check("t4_rd_pulses", DW'(rd_cnt), DW'(6));
    check("t4_empty_pop", DW'(empty_pop), DW'(0));

    // Early rlast on beat 10: sticky error, burst still completes by count
    push_off(7);
    send_burst(7, 2, 10, 0);
    drain();
    check("t5_err_sticky", DW'(err_burst), DW'(1));
    @(posedge clk);
    #1;
    check("t5_err_still", DW'(err_burst), DW'(1));

    // Reset during beat 7, then a clean burst with offset 2
    push_off(4);
    send_burst(4, 2, BL, 7);
    #1;
    check_outputs_zero("t6_async");
    @(posedge clk);
    #1;
    check_outputs_zero("t6_edge");
    rst_n = 1'b1;
    push_off(2);
    send_burst(2, 1, BL, 0);
    drain();
    check("t6_err", DW'(err_burst), DW'(0));

    // Randomized bursts with random gaps and random downstream ready
    rmode  = 2;
    gap_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      int unsigned o;
      o = $urandom_range(0, 15);
      push_off(o);
      send_burst(int'(o), 2, BL, 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    rmode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("final_rd_pulses", DW'(rd_cnt), DW'(n_push));
    check("final_fifo_left", DW'(fq.size()), DW'(0));
    check("final_empty_pop", DW'(empty_pop), DW'(0));
    check("final_err", DW'(err_burst), DW'(0));
    check("final_m_valid", DW'(m_valid), DW'(0));
    check("final_rready_viol", DW'(viol), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
